ex_muldiv: RTL and testbench

Iterative RV32M multiply/divide unit in the EX stage of the 5-stage pipeline. It consumes the two operands read from the register file in ID and forwarded through ID/EX, together with funct3. It holds the pipeline with a busy signal while it iterates, then presents one 32-bit result for one cycle, which the EX/MEM register captures toward writeback. Division-by-zero and signed overflow take a one-cycle fast path.

---
 rtl/ex_muldiv.sv | 159 +++++++++++++++
 tb/tb_ex_muldiv.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit for the EX stage.
// Shift-add multiply, restoring divide, one bit per cycle.
module ex_muldiv #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            EX_start,
  input  logic [2:0]      EX_funct3,
  input  logic [XLEN-1:0] EX_rs1_data,
  input  logic [XLEN-1:0] EX_rs2_data,
  input  logic            EX_flush,
  output logic            muldiv_busy,
  output logic            muldiv_valid,
  output logic [XLEN-1:0] muldiv_result
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   opa;
  logic [XLEN-1:0]   opb;
  logic [2:0]        fn;
  logic              neg;
  logic              neg_r;

  logic              a_sgn;
  logic              b_sgn;
  logic [XLEN-1:0]   a_abs;
  logic [XLEN-1:0]   b_abs;
  logic              fast_zero;
  logic              fast_ovf;
  logic [XLEN-1:0]   fast_res;
  logic [XLEN:0]     psum;
  logic [XLEN:0]     rsh;
  logic [XLEN:0]     rdiff;
  logic              ge;
  logic [2*XLEN-1:0] acc_nxt;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   rem;
  logic [XLEN-1:0]   fin;

  assign muldiv_busy = rst && ((state == CALC) ||
    (state == IDLE && EX_start && !EX_flush));

  always_comb begin
    a_sgn = 1'b0;
    b_sgn = 1'b0;
    unique case (EX_funct3)
      3'b000, 3'b001, 3'b100, 3'b110: begin
        a_sgn = EX_rs1_data[XLEN-1];
        b_sgn = EX_rs2_data[XLEN-1];
      end
      3'b010: a_sgn = EX_rs1_data[XLEN-1];
      default: ;
    endcase
    a_abs = a_sgn ? -EX_rs1_data : EX_rs1_data;
    b_abs = b_sgn ? -EX_rs2_data : EX_rs2_data;
  end

  always_comb begin
    fast_zero = EX_funct3[2] && (EX_rs2_data == '0);
    fast_ovf  = EX_funct3[2] && !EX_funct3[0] &&
      (EX_rs1_data == {1'b1, {(XLEN-1){1'b0}}}) &&
      (&EX_rs2_data);
    fast_res = '0;
    if (fast_zero)
      fast_res = EX_funct3[1] ? EX_rs1_data : '1;
    else if (fast_ovf)
      fast_res = EX_funct3[1] ? '0 : EX_rs1_data;
  end

  // One iteration: multiply adds into the high half and shifts right;
  // divide shifts the next dividend bit into the partial remainder.
  always_comb begin
    psum  = {1'b0, acc[2*XLEN-1:XLEN]} +
      ({1'b0, opa} & {(XLEN+1){opb[0]}});
    rsh   = {acc[2*XLEN-1:XLEN], opa[XLEN-1]};
    ge    = rsh >= {1'b0, opb};
    rdiff = rsh - {1'b0, opb};
    if (fn[2])
      acc_nxt = {ge ? rdiff[XLEN-1:0] : rsh[XLEN-1:0],
        acc[XLEN-2:0], ge};
    else
      acc_nxt = {psum, acc[XLEN-1:1]};
    prod = neg ? -acc_nxt : acc_nxt;
    quo  = neg ? -acc_nxt[XLEN-1:0] : acc_nxt[XLEN-1:0];
    rem  = neg_r ? -acc_nxt[2*XLEN-1:XLEN]
                 : acc_nxt[2*XLEN-1:XLEN];
    fin  = '0;
    unique case (1'b1)
      fn == 3'b000:             fin = prod[XLEN-1:0];
      !fn[2] && fn[1:0] != 0:   fin = prod[2*XLEN-1:XLEN];
      fn[2] && !fn[1]:          fin = quo;
      fn[2] && fn[1]:           fin = rem;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      cnt           <= '0;
      acc           <= '0;
      opa           <= '0;
      opb           <= '0;
      fn            <= '0;
      neg           <= 1'b0;
      neg_r         <= 1'b0;
      muldiv_valid  <= 1'b0;
      muldiv_result <= '0;
    end else begin
      muldiv_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (EX_start && !EX_flush) begin
            fn    <= EX_funct3;
            opa   <= a_abs;
            opb   <= b_abs;
            neg   <= a_sgn ^ b_sgn;
            neg_r <= a_sgn;
            acc   <= '0;
            cnt   <= CW'(XLEN-1);
            if (fast_zero || fast_ovf) begin
              muldiv_result <= fast_res;
              muldiv_valid  <= 1'b1;
              state         <= DONE;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          if (EX_flush) begin
            state <= IDLE;
          end else begin
            acc <= acc_nxt;
            cnt <= cnt - 1'b1;
            if (fn[2]) opa <= opa << 1;
            else       opb <= opb >> 1;
            if (cnt == '0) begin
              muldiv_result <= fin;
              muldiv_valid  <= 1'b1;
              state         <= DONE;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// Scoreboard bench for ex_muldiv: random and directed RV32M ops
// checked against a plain-arithmetic reference model.
module tb_ex_muldiv;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        EX_start = 1'b0;
  logic [2:0]  EX_funct3 = '0;
  logic [31:0] EX_rs1_data = '0;
  logic [31:0] EX_rs2_data = '0;
  logic        EX_flush = 1'b0;
  logic        muldiv_busy;
  logic        muldiv_valid;
  logic [31:0] muldiv_result;

  typedef struct {
    logic [31:0] res;
    int          cyc;
  } exp_t;

  exp_t        q[$];
  exp_t        mon_e;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_exp = '0;

  ex_muldiv #(.XLEN(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .EX_start      (EX_start),
    .EX_funct3     (EX_funct3),
    .EX_rs1_data   (EX_rs1_data),
    .EX_rs2_data   (EX_rs2_data),
    .EX_flush      (EX_flush),
    .muldiv_busy   (muldiv_busy),
    .muldiv_valid  (muldiv_valid),
    .muldiv_result (muldiv_result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_md(input logic [2:0] f,
      input logic [31:0] a, input logic [31:0] b);
    longint      sa;
    longint      sb;
    longint      ub;
    longint      p;
    logic [63:0] u;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'b0, b});
    u  = {32'b0, a} * {32'b0, b};
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: return u[63:32];
      3'd4: begin
        if (b == 0) return 32'hffffffff;
        p = sa / sb;
        return p[31:0];
      end
      3'd5: return (b == 0) ? 32'hffffffff : a / b;
      3'd6: begin
        if (b == 0) return a;
        p = sa % sb;
        return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_fast(input logic [2:0] f,
      input logic [31:0] a, input logic [31:0] b);
    return f[2] && (b == 0 || (!f[0] &&
      a == 32'h80000000 && b == 32'hffffffff));
  endfunction

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hffffffff;
      2: return 32'h80000000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Every valid pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst && muldiv_valid) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid act=%h exp=none", muldiv_result);
      end else begin
        mon_e = q.pop_front();
        chk("result", muldiv_result, mon_e.res);
        chk("latency", 32'(cyc), 32'(mon_e.cyc));
      end
    end
  end

  task automatic op(input logic [2:0] f, input logic [31:0] a,
                    input logic [31:0] b, input bit hold);
    exp_t e;
    int   lat;
    int   bc;
    int   n;
    @(negedge clk);
    EX_funct3   = f;
    EX_rs1_data = a;
    EX_rs2_data = b;
    EX_start    = 1'b1;
    lat   = is_fast(f, a, b) ? 1 : 33;
    e.res = ref_md(f, a, b);
    e.cyc = cyc + lat;
    q.push_back(e);
    last_exp = e.res;
    #1 chk("busy_start", 32'(muldiv_busy), 32'd1);
    @(negedge clk);
    if (!hold) EX_start = 1'b0;
    bc = 0;
    n  = 0;
    while (!muldiv_valid && n < 40) begin
      if (muldiv_busy) bc++;
      n++;
      @(negedge clk);
    end
    if (!muldiv_valid) begin
      checks++;
      errors++;
      $display("FAIL timeout act=no_valid exp=valid f=%0d", f);
    end
    chk("busy_cycles", 32'(bc), 32'(lat - 1));
  endtask

  initial begin
    #1;
    chk("rst_busy", 32'(muldiv_busy), 32'd0);
    chk("rst_valid", 32'(muldiv_valid), 32'd0);
    chk("rst_result", muldiv_result, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    op(3'd0, 32'hffffffff, 32'h2, 1'b0);
    op(3'd1, 32'hffffffff, 32'h2, 1'b0);
    op(3'd3, 32'hffffffff, 32'h2, 1'b0);
    op(3'd2, 32'hffffffff, 32'h2, 1'b0);
    op(3'd4, 32'hfffffff9, 32'h2, 1'b0);
    op(3'd6, 32'hfffffff9, 32'h2, 1'b0);
    op(3'd5, 32'hfffffff9, 32'h2, 1'b0);
    op(3'd7, 32'hfffffff9, 32'h2, 1'b0);
    op(3'd5, 32'd5, 32'd0, 1'b0);
    op(3'd6, 32'd5, 32'd0, 1'b0);
    op(3'd4, 32'h80000000, 32'hffffffff, 1'b0);
    op(3'd6, 32'h80000000, 32'hffffffff, 1'b0);
    op(3'd4, 32'd7, 32'd0, 1'b0);
    op(3'd7, 32'd9, 32'd0, 1'b0);

    // Flush mid-CALC: no valid, result untouched.
    @(negedge clk);
    EX_funct3   = 3'd4;
    EX_rs1_data = 32'd100;
    EX_rs2_data = 32'd3;
    EX_start    = 1'b1;
    @(negedge clk);
    EX_start = 1'b0;
    repeat (4) @(negedge clk);
    EX_flush = 1'b1;
    @(negedge clk);
    EX_flush = 1'b0;
    #1;
    chk("flush_busy", 32'(muldiv_busy), 32'd0);
    chk("flush_valid", 32'(muldiv_valid), 32'd0);
    chk("flush_result", muldiv_result, last_exp);
    repeat (40) @(negedge clk);

    // Start together with flush is not accepted.
    EX_start = 1'b1;
    EX_flush = 1'b1;
    #1 chk("startflush_busy", 32'(muldiv_busy), 32'd0);
    @(negedge clk);
    EX_start = 1'b0;
    EX_flush = 1'b0;
    #1 chk("startflush_idle", 32'(muldiv_busy), 32'd0);
    repeat (40) @(negedge clk);
    op(3'd4, 32'd100, 32'd3, 1'b0);

    // Reset in the middle of CALC.
    @(negedge clk);
    EX_funct3   = 3'd0;
    EX_rs1_data = 32'h1234;
    EX_rs2_data = 32'h5678;
    EX_start    = 1'b1;
    @(negedge clk);
    EX_start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_busy", 32'(muldiv_busy), 32'd0);
    chk("midrst_valid", 32'(muldiv_valid), 32'd0);
    chk("midrst_result", muldiv_result, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    op(3'd0, 32'd3, 32'd4, 1'b0);

    // Start held high through a whole op, then back-to-back.
    op(3'd0, 32'd6, 32'd7, 1'b1);
    op(3'd3, 32'hdeadbeef, 32'h12345678, 1'b0);

    for (int i = 0; i < 60; i++)
      op(3'($urandom_range(0, 7)), rnd_opnd(), rnd_opnd(), 1'b0);

    repeat (5) @(negedge clk);
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
